// File: rtl/done_seq_gen_pkg.sv
// Shared constants for the per-step done-signal generator: state encoding,
// default slot count and the one-hot shifter operation codes.
`ifndef WIDTH_TIME
`define WIDTH_TIME 64
`endif

package done_seq_gen_pkg;

  // Scheduler and solver stages size their slot vectors from this value.
  localparam int DEF_NUM_SLOTS = 350;
  localparam int DEF_CNT_W     = 12;
  localparam int DEF_TIME_W    = `WIDTH_TIME;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'd0,
    SR_LOAD  = 2'd1,
    SR_SHIFT = 2'd2,
    SR_CLEAR = 2'd3
  } sr_op_e;

endpackage

// File: rtl/done_seq_gen_if.sv
// Scheduler-facing bundle of the done-sequence generator: step request and
// control in, slot strobes and status out.
interface done_seq_gen_if
  import done_seq_gen_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIME_W    = DEF_TIME_W
);
  logic                 start;
  logic [TIME_W-1:0]    sim_time;
  logic [CNT_W-1:0]     last_slot;
  logic                 hold;
  logic                 abort;
  logic [NUM_SLOTS:0]   done_sig;
  logic [CNT_W-1:0]     slot;
  logic                 busy;
  logic                 step_done;
  logic                 overrun;

  modport master (
    output start, sim_time, last_slot, hold, abort,
    input  done_sig, slot, busy, step_done, overrun
  );

  modport slave (
    input  start, sim_time, last_slot, hold, abort,
    output done_sig, slot, busy, step_done, overrun
  );
endinterface

// File: rtl/done_seq_gen_onehot_shift_reg.sv
// One-hot strobe register: loads bit 1, walks left one position per shift,
// holds or clears. Bit 0 is never set.
module onehot_shift_reg
  import done_seq_gen_pkg::*;
#(
  parameter int W = DEF_NUM_SLOTS + 1
) (
  input  logic         clk,
  input  logic         sta,
  input  sr_op_e       op,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge sta) begin
    if (sta) begin
      q <= '0;
    end else begin
      case (op)
        SR_LOAD:  q <= W'(2);
        SR_SHIFT: q <= {q[W-2:0], 1'b0};
        SR_CLEAR: q <= '0;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/done_seq_gen.sv
// Per-step done-signal generator: walks a one-hot strobe over slots
// 1..last_slot once per accepted start, with hold, abort and overrun tracking.
module done_seq_gen
  import done_seq_gen_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIME_W    = DEF_TIME_W
) (
  input logic           clk,
  input logic           sta,
  done_seq_gen_if.slave bus
);

  localparam int DS_W = NUM_SLOTS + 1;
  localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(NUM_SLOTS);
  localparam logic [DS_W-1:0]  DS_ONE   = DS_W'(1);

  if ((2 ** CNT_W) <= NUM_SLOTS) begin : g_cnt_w_check
    $error("done_seq_gen: CNT_W too narrow for NUM_SLOTS");
  end

  state_e           state_q, state_d;
  sr_op_e           sr_op;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] last_clamped;
  logic             step_done_q, step_done_d;
  logic             overrun_q;
  logic [DS_W-1:0]  done_sig_q;
  logic             accept;
  logic             at_last;

  assign accept       = bus.start && (bus.sim_time != '0) && !bus.abort;
  assign at_last      = (slot_q == last_q);
  // Zero or out-of-range step lengths fall back to the full slot range.
  assign last_clamped = ((bus.last_slot == '0) || (bus.last_slot > LAST_MAX))
                        ? LAST_MAX : bus.last_slot;

  always_ff @(posedge clk or posedge sta) begin
    if (sta) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (bus.abort || (!bus.hold && at_last)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort outranks hold, which outranks both advance and completion.
  always_comb begin
    sr_op       = SR_HOLD;
    slot_d      = slot_q;
    last_d      = last_q;
    step_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_op  = SR_LOAD;
          slot_d = CNT_W'(1);
          last_d = last_clamped;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          sr_op  = SR_CLEAR;
          slot_d = '0;
        end else if (bus.hold) begin
          sr_op  = SR_HOLD;
        end else if (at_last) begin
          sr_op       = SR_CLEAR;
          slot_d      = '0;
          step_done_d = 1'b1;
        end else begin
          sr_op  = SR_SHIFT;
          slot_d = slot_q + CNT_W'(1);
        end
      end
      default: begin
        sr_op  = SR_CLEAR;
        slot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge sta) begin
    if (sta) begin
      slot_q      <= '0;
      last_q      <= LAST_MAX;
      step_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      last_q      <= last_d;
      step_done_q <= step_done_d;
      // Includes the completion cycle: the sequence is still busy there.
      if (bus.start && (state_q == ST_RUN)) overrun_q <= 1'b1;
    end
  end

  onehot_shift_reg #(.W(DS_W)) u_strobe (
    .clk (clk),
    .sta (sta),
    .op  (sr_op),
    .q   (done_sig_q)
  );

  assign bus.done_sig  = done_sig_q;
  assign bus.slot      = slot_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.step_done = step_done_q;
  assign bus.overrun   = overrun_q;

  a_onehot0 : assert property (@(posedge clk) disable iff (sta)
    $onehot0(done_sig_q));
  a_slot_strobe : assert property (@(posedge clk) disable iff (sta)
    (state_q == ST_RUN) |-> (done_sig_q == (DS_ONE << slot_q)));
  a_slot_bound : assert property (@(posedge clk) disable iff (sta)
    slot_q <= last_q);

endmodule

// File: tb/tb_done_seq_gen.sv
// Directed bench for done_seq_gen: stimulus pushes the hand-derived state
// expected after each edge; a monitor pops and compares it every cycle.
module tb_done_seq_gen;
  import done_seq_gen_pkg::*;

  localparam int NS = DEF_NUM_SLOTS;
  localparam int CW = DEF_CNT_W;
  localparam int TW = DEF_TIME_W;
  localparam logic [NS:0] ONE = 1;

  typedef struct {
    string tag;
    int    slot;
    bit    busy;
    bit    sd;
    bit    ov;
  } exp_t;

  logic clk = 1'b0;
  logic sta = 1'b1;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  done_seq_gen_if #(.NUM_SLOTS(NS), .CNT_W(CW), .TIME_W(TW)) bus ();

  done_seq_gen #(.NUM_SLOTS(NS), .CNT_W(CW), .TIME_W(TW)) dut (
    .clk (clk),
    .sta (sta),
    .bus (bus.slave)
  );

  // Monitor: the DUT presents a new output set every edge; check it 2 time
  // units later against the oldest outstanding expectation.
  initial begin
    exp_t        e;
    logic [NS:0] ds;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ds = (e.slot == 0) ? '0 : (ONE << e.slot);
        n_vec++;
        if (bus.done_sig !== ds || bus.slot !== CW'(e.slot) ||
            bus.busy !== e.busy || bus.step_done !== e.sd ||
            bus.overrun !== e.ov) begin
          n_err++;
          $display("FAIL %s: got done_sig=%h slot=%0d busy=%b step_done=%b overrun=%b, want done_sig=%h slot=%0d busy=%b step_done=%b overrun=%b",
                   e.tag, bus.done_sig, bus.slot, bus.busy, bus.step_done, bus.overrun,
                   ds, e.slot, e.busy, e.sd, e.ov);
        end
      end
    end
  end

  // Inputs are set ~1 unit after a falling edge; the expectation describes
  // the outputs after the next rising edge. start/abort are single-cycle.
  task automatic tick(input string tag, input int s, input bit b, input bit d, input bit o);
    exp_q.push_back('{tag, s, b, d, o});
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.sim_time  = '0;
    bus.last_slot = '0;
    bus.hold      = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    #1;

    // 1: reset, then start at sim_time 0 is ignored
    tick("reset0", 0, 0, 0, 0);
    tick("reset1", 0, 0, 0, 0);
    sta = 1'b0;
    bus.sim_time = '0; bus.last_slot = CW'(4); bus.start = 1'b1;
    tick("simtime0_start", 0, 0, 0, 0);
    tick("simtime0_idle", 0, 0, 0, 0);
    bus.sim_time = TW'(5); bus.start = 1'b1; bus.abort = 1'b1;
    tick("idle_start_abort", 0, 0, 0, 0);

    // 2: four-slot step
    bus.last_slot = CW'(4); bus.start = 1'b1;
    for (int i = 1; i <= 4; i++) tick("step4", i, 1, 0, 0);
    tick("step4_done", 0, 0, 1, 0);
    tick("step4_idle", 0, 0, 0, 0);

    // 3: last_slot 0 and 400 both clamp to the full range
    bus.sim_time = TW'(1); bus.last_slot = '0; bus.start = 1'b1;
    for (int i = 1; i <= NS; i++) tick("full_ls0", i, 1, 0, 0);
    tick("full_ls0_done", 0, 0, 1, 0);
    bus.last_slot = CW'(400); bus.start = 1'b1;
    for (int i = 1; i <= NS; i++) tick("full_ls400", i, 1, 0, 0);
    tick("full_ls400_done", 0, 0, 1, 0);
    tick("full_idle", 0, 0, 0, 0);

    // 4: hold three cycles at slot 5; MSB-set sim_time still counts as >= 1
    bus.sim_time = {1'b1, {(TW-1){1'b0}}}; bus.last_slot = CW'(10); bus.start = 1'b1;
    for (int i = 1; i <= 5; i++) tick("hold_pre", i, 1, 0, 0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) tick("hold_frozen", 5, 1, 0, 0);
    bus.hold = 1'b0;
    for (int i = 6; i <= 10; i++) tick("hold_post", i, 1, 0, 0);
    tick("hold_done", 0, 0, 1, 0);

    // 5: abort at slot 7, restart, then abort beats hold
    bus.sim_time = TW'(3); bus.last_slot = CW'(20); bus.start = 1'b1;
    for (int i = 1; i <= 7; i++) tick("abort_run", i, 1, 0, 0);
    bus.abort = 1'b1;
    tick("abort_clear", 0, 0, 0, 0);
    tick("abort_idle", 0, 0, 0, 0);
    bus.start = 1'b1;
    tick("restart1", 1, 1, 0, 0);
    tick("restart2", 2, 1, 0, 0);
    bus.hold = 1'b1; bus.abort = 1'b1;
    tick("abort_over_hold", 0, 0, 0, 0);
    bus.hold = 1'b0;
    tick("abort2_idle", 0, 0, 0, 0);

    // degenerate one-slot step; start on the completion cycle is an overrun
    bus.last_slot = CW'(1); bus.start = 1'b1;
    tick("one_slot", 1, 1, 0, 0);
    bus.start = 1'b1;
    tick("one_slot_done_ovr", 0, 0, 1, 1);
    tick("one_slot_idle", 0, 0, 0, 1);
    sta = 1'b1;
    tick("reset_ovr", 0, 0, 0, 0);
    sta = 1'b0;

    // 6: start again at slot 3 sets overrun, sequence runs to 8 untouched
    bus.last_slot = CW'(8); bus.start = 1'b1;
    for (int i = 1; i <= 3; i++) tick("ovr_pre", i, 1, 0, 0);
    bus.start = 1'b1;
    for (int i = 4; i <= 8; i++) tick("ovr_run", i, 1, 0, 1);
    tick("ovr_done", 0, 0, 1, 1);
    bus.last_slot = CW'(2); bus.start = 1'b1;
    tick("ovr_sticky1", 1, 1, 0, 1);
    tick("ovr_sticky2", 2, 1, 0, 1);
    tick("ovr_sticky_done", 0, 0, 1, 1);
    bus.start = 1'b1;
    tick("ovr_mid", 1, 1, 0, 1);
    sta = 1'b1;
    tick("reset_midseq", 0, 0, 0, 0);
    sta = 1'b0;
    tick("post_reset", 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/done_seq_gen.md
Name: done_seq_gen

Overview:
- Parametrised successor to the per-step done-signal generator in the real-time simulation datapath.
- Owns its slot counter instead of decoding an external one. Drives a one-hot `done_sig` vector that walks slot 1..last_slot once per simulation step.
- Adds runtime step length, hold/pause, synchronous abort, an end-of-step pulse and a sticky overrun flag.
- Sits between the step scheduler, which issues `start`, and the solver stages, each of which consumes one `done_sig` bit.

Parameters:
- NUM_SLOTS, 350: highest slot index; `done_sig` is NUM_SLOTS+1 bits wide and bit 0 is never asserted.
- CNT_W, 12: slot counter width; must satisfy 2^CNT_W > NUM_SLOTS (elaboration-time check).
- TIME_W, `WIDTH_TIME: width of `sim_time`.

Ports:
- clk  in  1  system clock, rising edge.
- sta  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin one step sequence.
- sim_time  in  TIME_W  current simulation time; a sequence runs only when sim_time >= 1.
- last_slot  in  CNT_W  final slot of the step; sampled on an accepted start.
- hold  in  1  freezes slot advance while high.
- abort  in  1  synchronous cancel of the running sequence.
- done_sig  out  NUM_SLOTS+1  one-hot active-slot strobe, registered.
- slot  out  CNT_W  current slot index; 0 when idle.
- busy  out  1  high while in RUN.
- step_done  out  1  one-cycle pulse when a sequence completes normally.
- overrun  out  1  sticky; set on a start while busy.

Behaviour:
- Reset (`sta` high, asynchronous, any state, including mid-sequence):
  - done_sig=0, slot=0, busy=0, step_done=0, overrun=0.
  - State returns to IDLE.
  - last_slot_q=NUM_SLOTS.
- States: IDLE and RUN. All outputs are registered and none is combinational from inputs.
- IDLE:
  - Accept condition: start=1, sim_time>=1 and abort=0.
  - On accept, at that edge: slot<=1, done_sig<=bit1 only, busy<=1, RUN.
  - Latency from start to first strobe is 1 edge.
  - last_slot_q latches at the same edge. last_slot==0 or last_slot>NUM_SLOTS clamps to NUM_SLOTS.
  - start with sim_time==0 is ignored: no flag, no output change.
- RUN, advance:
  - Condition: hold=0, abort=0 and slot<last_slot_q.
  - slot<=slot+1; done_sig shifts left one position, so exactly one bit stays high and the previous bit clears at the same edge.
- RUN, hold=1 (and abort=0): slot and done_sig are frozen, busy stays 1.
- RUN, completion:
  - Condition: slot==last_slot_q, hold=0, abort=0.
  - Next edge: done_sig<=0, slot<=0, busy<=0, step_done<=1 for exactly one cycle, IDLE.
  - A start in that same cycle is a start-while-busy: it is not accepted and it sets overrun. A new sequence can begin one cycle after step_done.
- RUN, abort=1: abort has priority over hold and completion. Next edge: done_sig<=0, slot<=0, busy<=0, IDLE. step_done stays 0.
- overrun: set on any edge with start=1 while busy=1. The running sequence continues unaffected. Cleared only by sta.
- Invariant: done_sig is one-hot or zero every cycle. done_sig[slot]==1 whenever busy=1.
- Degenerate step, last_slot_q==1: strobe lasts 1 cycle, then step_done the next edge.
- Width rules:
  - slot never exceeds last_slot_q, so there is no counter wrap.
  - sim_time comparison is unsigned.

Decomposition:
- Shared package / global parameter include:
  - `WIDTH_TIME` (already global).
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default NUM_SLOTS value, so scheduler and solver stages agree on the slot count.
- One sub-module is natural: onehot_shift_reg (NUM_SLOTS+1 bits). Operations: load bit1, shift, hold, clear. Async clear on sta.
- The FSM, counter, clamp and flags stay in the top module.

Test Plan:
1. Pulse sta, then start with sim_time=0 -> all outputs 0, busy stays 0.
2. sim_time=5, last_slot=4, start -> done_sig bits 1,2,3,4 on four consecutive cycles. Next cycle done_sig=0, step_done=1 for 1 cycle, busy=0.
3. sim_time=1, last_slot=0, start -> runs slots 1..350. done_sig[350] high for 1 cycle, then step_done. One-hot invariant checked on every cycle.
4. last_slot=10, hold high for 3 cycles at slot 5 -> slot=5 and done_sig[5] held for 4 cycles total, then slot 6. step_done arrives 3 cycles later than in the unheld case.
5. last_slot=20, abort at slot 7 -> next cycle done_sig=0, slot=0, busy=0, no step_done. A start two cycles later begins again at slot 1.
6. last_slot=8, start repeated at slot 3 -> overrun=1 and sequence completes normally at slot 8. overrun stays 1 through later steps until sta, then 0.
